i2s_tx: RTL and testbench
=========================

I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 Parameter width_p, default 12: sample width in bits, signed two's complement; SHALL satisfy width_p <= slot_width_p-1.
REQ-002 Parameter slot_width_p, default 16: bclk periods per channel slot.
REQ-003 Parameter bclk_div_p, default 2: clk_i cycles per bclk half-period; SHALL be >= 1.
REQ-004 clk_i  input  1  single clock; all state SHALL be on its rising edge.
REQ-005 reset_n_i  input  1  asynchronous, active-low reset.
REQ-006 data_i  input  width_p  signed sample from the upstream stream source.
REQ-007 valid_i  input  1  data_i holds a valid sample.
REQ-008 ready_o  output  1  block accepts data_i this cycle.
REQ-009 bclk_o  output  1  I2S bit clock.
REQ-010 lrclk_o  output  1  I2S word select; 0 = left slot, 1 = right slot.
REQ-011 sdata_o  output  1  I2S serial data, MSB first.
REQ-012 underrun_o  output  1  one-cycle pulse when a frame starts with no sample available.

Function
REQ-013 Divider counter SHALL count 0..bclk_div_p-1; "tick" = cycle in which it equals bclk_div_p-1; counter wraps to 0 on tick.
REQ-014 bclk_o SHALL toggle on every tick; "falling tick" = tick while bclk_o=1.
REQ-015 Bit counter b SHALL span 0..2*slot_width_p-1, increment on each falling tick, and wrap from 2*slot_width_p-1 to 0.
REQ-016 Frame start = falling tick on which b wraps to 0.
REQ-017 On the same falling tick that updates b, lrclk_o SHALL become 1 when new b >= slot_width_p, else 0.
REQ-018 With p = b mod slot_width_p, sdata_o SHALL be frame_sample[width_p-p] for 1 <= p <= width_p, else 0 (standard I2S one-bit delay, zero padding).
REQ-019 The same frame_sample SHALL be sent in both the left and right slots (mono duplicated to stereo).
REQ-020 One-entry holding register: ready_o SHALL equal NOT hold_valid (registered, no combinational path from valid_i).
REQ-021 Handshake: when valid_i & ready_o, data_i SHALL be captured into the holding register and hold_valid set at the next edge.
REQ-022 At frame start, if hold_valid=1, frame_sample SHALL load the held sample and hold_valid SHALL clear.
REQ-023 At frame start, if hold_valid=0, frame_sample SHALL load 0 and underrun_o SHALL pulse high for exactly that cycle.
REQ-024 Handshake coinciding with a frame start that finds hold_valid=0: underrun SHALL still be flagged, a zero frame SHALL be sent, and the accepted sample SHALL be held for the next frame.
REQ-025 bclk_o, lrclk_o and sdata_o SHALL be driven directly from flops.
REQ-026 valid_i dropping before the handshake SHALL NOT corrupt state; data_i SHALL be sampled only on a handshake.

Reset
REQ-027 While reset_n_i=0, asynchronously: divider=0, bclk_o=0, b=2*slot_width_p-1, lrclk_o=1, sdata_o=0, frame_sample=0, hold_valid=0 (ready_o=1), underrun_o=0.
REQ-028 The first falling tick after reset release SHALL be a frame start.
REQ-029 Reset asserted mid-frame SHALL discard the held sample and the in-flight frame; no underrun pulse SHALL be produced during reset.

Verification (defaults: bclk period 4 clk, frame 128 clk)
REQ-030 Reset: reset_n_i=0 -> bclk_o=0, lrclk_o=1, sdata_o=0, ready_o=1, underrun_o=0.
REQ-031 Sample 12'sh5A3 valid in the first cycle after release -> ready_o=0 next cycle; at 4th edge lrclk_o=0, no underrun; left p=1..12 = 010110100011, p=0 and 13..15 = 0; right slot identical.
REQ-032 Back-pressure: hold full, valid_i held with 12'sh123 -> ready_o=0 until the frame start, handshake the cycle after, 12'sh123 sent in the following frame.
REQ-033 Underrun: valid_i=0 continuously -> sdata_o=0 throughout, underrun_o high one cycle every 128 clk at each lrclk_o 1->0.
REQ-034 Full-scale negative 12'sh800 -> each slot p=1 is 1, p=2..15 are 0.
REQ-035 reset_n_i low at b=20 with hold full -> all REQ-027 values immediately; after release, first frame is an underrun.

Source files
------------

// File: rtl/i2s_tx.sv
// I2S transmitter: takes signed mono samples through a one-entry
// valid/ready holding register and serialises each sample MSB first
// into both the left and right slots of an I2S frame, with the usual
// one-bit delay after the word-select edge and zero padding.
module i2s_tx #(
   parameter int width_p      = 12,
   parameter int slot_width_p = 16,
   parameter int bclk_div_p   = 2
) (
   input  logic               clk_i,
   input  logic               reset_n_i,
   input  logic [width_p-1:0] data_i,
   input  logic               valid_i,
   output logic               ready_o,
   output logic               bclk_o,
   output logic               lrclk_o,
   output logic               sdata_o,
   output logic               underrun_o
);

   localparam int DW = (bclk_div_p > 1) ? $clog2(bclk_div_p) : 1;
   localparam int BW = $clog2(2 * slot_width_p);
   localparam int PW = (slot_width_p > 1) ? $clog2(slot_width_p) : 1;

   localparam logic [DW-1:0] DIV_LAST = DW'(bclk_div_p - 1);
   localparam logic [BW-1:0] B_LAST   = BW'(2 * slot_width_p - 1);
   localparam logic [BW-1:0] S_VAL    = BW'(slot_width_p);

   logic [DW-1:0]      div_reg, div_next;
   logic               bclk_reg, bclk_next;
   logic [BW-1:0]      b_reg, b_next;
   logic               lrclk_reg, lrclk_next;
   logic               sdata_reg, sdata_next;
   logic [width_p-1:0] frame_sample_reg, frame_sample_next;
   logic [width_p-1:0] hold_data_reg, hold_data_next;
   logic               hold_valid_reg, hold_valid_next;
   logic               underrun_reg, underrun_next;

   logic               tick;
   logic               falling_tick;
   logic               frame_start;
   logic               handshake;
   logic [BW-1:0]      b_wrap;
   logic               lrclk_wrap;
   logic [PW-1:0]      p_wrap;
   logic [slot_width_p-1:0] slot_bits;

   // Slot bit pattern indexed by position p inside a slot: p=0 is the
   // one-bit delay slot, p=1..width_p carry the sample MSB first, the
   // rest of the slot is zero padding.
   genvar gi;
   generate
      for (gi = 0; gi < slot_width_p; gi++) begin : g_slot
         if (gi >= 1 && gi <= width_p) begin : g_data
            assign slot_bits[gi] = frame_sample_reg[width_p-gi];
         end else begin : g_pad
            assign slot_bits[gi] = 1'b0;
         end
      end
   endgenerate

   assign tick         = (div_reg == DIV_LAST);
   assign falling_tick = tick & bclk_reg;
   assign frame_start  = falling_tick & (b_reg == B_LAST);
   assign handshake    = valid_i & ~hold_valid_reg;

   assign b_wrap     = (b_reg == B_LAST) ? '0 : b_reg + 1'b1;
   assign lrclk_wrap = (b_wrap >= S_VAL);
   assign p_wrap     = PW'(lrclk_wrap ? (b_wrap - S_VAL) : b_wrap);

   // Next-state logic for divider, bit position, serial outputs and the
   // holding register; every register keeps its value by default.
   always_comb begin
      div_next          = div_reg;
      bclk_next         = bclk_reg;
      b_next            = b_reg;
      lrclk_next        = lrclk_reg;
      sdata_next        = sdata_reg;
      frame_sample_next = frame_sample_reg;
      hold_data_next    = hold_data_reg;
      hold_valid_next   = hold_valid_reg;
      underrun_next     = 1'b0;

      if (tick) begin
         div_next  = '0;
         bclk_next = ~bclk_reg;
      end else begin
         div_next = div_reg + 1'b1;
      end

      // New bit position and the matching word select / data bit are
      // all produced on the falling edge of bclk.
      if (falling_tick) begin
         b_next     = b_wrap;
         lrclk_next = lrclk_wrap;
         sdata_next = slot_bits[p_wrap];
      end

      // A handshake is only possible while the holding register is
      // empty, so it never collides with the hold being drained below.
      if (handshake) begin
         hold_data_next  = data_i;
         hold_valid_next = 1'b1;
      end

      if (frame_start) begin
         if (hold_valid_reg) begin
            frame_sample_next = hold_data_reg;
            hold_valid_next   = 1'b0;
         end else begin
            frame_sample_next = '0;
            underrun_next     = 1'b1;
         end
      end
   end

   // State register; reset parks the bit counter on the last bit of the
   // right slot so the first falling bclk edge starts a new frame.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         div_reg          <= '0;
         bclk_reg         <= 1'b0;
         b_reg            <= B_LAST;
         lrclk_reg        <= 1'b1;
         sdata_reg        <= 1'b0;
         frame_sample_reg <= '0;
         hold_data_reg    <= '0;
         hold_valid_reg   <= 1'b0;
         underrun_reg     <= 1'b0;
      end else begin
         div_reg          <= div_next;
         bclk_reg         <= bclk_next;
         b_reg            <= b_next;
         lrclk_reg        <= lrclk_next;
         sdata_reg        <= sdata_next;
         frame_sample_reg <= frame_sample_next;
         hold_data_reg    <= hold_data_next;
         hold_valid_reg   <= hold_valid_next;
         underrun_reg     <= underrun_next;
      end
   end

   assign ready_o    = ~hold_valid_reg;
   assign bclk_o     = bclk_reg;
   assign lrclk_o    = lrclk_reg;
   assign sdata_o    = sdata_reg;
   assign underrun_o = underrun_reg;

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx with default parameters (bclk period 4 clk,
// frame 128 clk). Frames are captured one bit per bclk period starting
// at the frame-start edge and compared with hand-built slot patterns.
module tb_i2s_tx;

   logic        clk_i;
   logic        reset_n_i;
   logic [11:0] data_i;
   logic        valid_i;
   logic        ready_o;
   logic        bclk_o;
   logic        lrclk_o;
   logic        sdata_o;
   logic        underrun_o;

   int checks;
   int errors;

   i2s_tx dut (
      .clk_i      (clk_i),
      .reset_n_i  (reset_n_i),
      .data_i     (data_i),
      .valid_i    (valid_i),
      .ready_o    (ready_o),
      .bclk_o     (bclk_o),
      .lrclk_o    (lrclk_o),
      .sdata_o    (sdata_o),
      .underrun_o (underrun_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // Expected frames: slot = 0, sample MSB first, three zero pad bits,
   // repeated for the right slot.
   localparam logic [31:0] FRAME_5A3  = 32'h2D18_2D18;
   localparam logic [31:0] FRAME_123  = 32'h0918_0918;
   localparam logic [31:0] FRAME_800  = 32'h4000_4000;
   localparam logic [31:0] FRAME_ZERO = 32'h0000_0000;
   localparam logic [31:0] LR_FRAME   = 32'h0000_FFFF;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Called at the negedge right after a frame-start edge; returns at
   // the negedge right after the next frame-start edge.
   task automatic check_frame(input string tag, input logic [31:0] exp_data, input logic exp_unr);
      logic [31:0] d;
      logic [31:0] l;
      logic        u;
      d = '0;
      l = '0;
      u = underrun_o;
      check({tag, "_underrun"}, {31'd0, u}, {31'd0, exp_unr});
      for (int k = 0; k < 32; k++) begin
         d = {d[30:0], sdata_o};
         l = {l[30:0], lrclk_o};
         repeat (4) @(negedge clk_i);
      end
      check({tag, "_sdata"}, d, exp_data);
      check({tag, "_lrclk"}, l, LR_FRAME);
      $display("frame %s: underrun=%b sdata=%h lrclk=%h", tag, u, d, l);
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      reset_n_i = 1'b0;
      valid_i   = 1'b0;
      data_i    = '0;

      // Reset state
      repeat (3) @(negedge clk_i);
      check("rst_bclk",     {31'd0, bclk_o},     32'd0);
      check("rst_lrclk",    {31'd0, lrclk_o},    32'd1);
      check("rst_sdata",    {31'd0, sdata_o},    32'd0);
      check("rst_ready",    {31'd0, ready_o},    32'd1);
      check("rst_underrun", {31'd0, underrun_o}, 32'd0);
      $display("reset: bclk=%b lrclk=%b sdata=%b ready=%b underrun=%b",
               bclk_o, lrclk_o, sdata_o, ready_o, underrun_o);

      // Release and offer 0x5A3 in the first cycle
      reset_n_i = 1'b1;
      valid_i   = 1'b1;
      data_i    = 12'h5A3;
      @(negedge clk_i);
      check("hs1_ready", {31'd0, ready_o}, 32'd0);
      // Back-pressure: keep 0x123 valid while the hold is full
      data_i = 12'h123;
      @(negedge clk_i);
      @(negedge clk_i);
      check("bp_hold_ready", {31'd0, ready_o}, 32'd0);
      @(negedge clk_i);
      check("f1_lrclk_edge", {31'd0, lrclk_o}, 32'd0);

      // Frame 1 (0x5A3) while 0x123 is accepted the cycle after frame start
      fork
         check_frame("f1_5a3", FRAME_5A3, 1'b0);
         begin
            check("bp_release_ready", {31'd0, ready_o}, 32'd1);
            @(negedge clk_i);
            check("bp_accept_ready", {31'd0, ready_o}, 32'd0);
            valid_i = 1'b0;
         end
      join

      // Frame 2 (0x123) while 0x800 is loaded for frame 3
      fork
         check_frame("f2_123", FRAME_123, 1'b0);
         begin
            check("f2_ready", {31'd0, ready_o}, 32'd1);
            valid_i = 1'b1;
            data_i  = 12'h800;
            @(negedge clk_i);
            valid_i = 1'b0;
            check("f2_accept_ready", {31'd0, ready_o}, 32'd0);
         end
      join

      // Frame 3: full-scale negative
      check_frame("f3_800", FRAME_800, 1'b0);

      // Frame 4: nothing offered -> underrun, silent frame
      check_frame("f4_unr", FRAME_ZERO, 1'b1);

      // Frame 5: underrun again; offer 0x5A3 exactly on the next frame start
      fork
         check_frame("f5_unr", FRAME_ZERO, 1'b1);
         begin
            @(negedge clk_i);
            check("unr_pulse_width", {31'd0, underrun_o}, 32'd0);
            repeat (126) @(negedge clk_i);
            valid_i = 1'b1;
            data_i  = 12'h5A3;
         end
      join
      check("coincide_ready", {31'd0, ready_o}, 32'd0);
      valid_i = 1'b0;

      // Frame 6: zero frame despite the coinciding handshake
      check_frame("f6_unr_coincide", FRAME_ZERO, 1'b1);

      // Frame 7: the held 0x5A3; meanwhile load 0x123 for frame 8
      fork
         check_frame("f7_5a3", FRAME_5A3, 1'b0);
         begin
            valid_i = 1'b1;
            data_i  = 12'h123;
            @(negedge clk_i);
            valid_i = 1'b0;
         end
      join

      // Frame 8 sends 0x123; fill the hold with 0x800, reset at b=20
      valid_i = 1'b1;
      data_i  = 12'h800;
      @(negedge clk_i);
      valid_i = 1'b0;
      repeat (80) @(negedge clk_i);
      check("pre_rst_sdata", {31'd0, sdata_o}, 32'd1);
      check("pre_rst_ready", {31'd0, ready_o}, 32'd0);
      #1 reset_n_i = 1'b0;
      #1;
      check("midrst_bclk",     {31'd0, bclk_o},     32'd0);
      check("midrst_lrclk",    {31'd0, lrclk_o},    32'd1);
      check("midrst_sdata",    {31'd0, sdata_o},    32'd0);
      check("midrst_ready",    {31'd0, ready_o},    32'd1);
      check("midrst_underrun", {31'd0, underrun_o}, 32'd0);
      $display("mid-frame reset: bclk=%b lrclk=%b sdata=%b ready=%b underrun=%b",
               bclk_o, lrclk_o, sdata_o, ready_o, underrun_o);
      repeat (3) @(negedge clk_i);
      check("rst_hold_underrun", {31'd0, underrun_o}, 32'd0);
      reset_n_i = 1'b1;
      repeat (4) @(negedge clk_i);
      check("post_rst_lrclk", {31'd0, lrclk_o}, 32'd0);
      check("post_rst_ready", {31'd0, ready_o}, 32'd1);
      check_frame("f9_post_rst", FRAME_ZERO, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
